// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch front end.
// Owns the program counter, presents it to the instruction memory as a byte
// address, and captures the returned word into an output register that is
// handed downstream over a valid/ready handshake. Taken branches and jumps
// redirect the PC. A misaligned redirect or an out-of-range fetch parks the
// unit in a terminal FAULT state that only reset leaves.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        misalign_o,
    output logic        oob_o,
    output logic [31:0] fetch_cnt
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    // IDLE : first cycle out of reset, the address settles, no capture.
    // RUN  : normal fetch.
    // FAULT: terminal, everything frozen until reset.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    // Memory depth widened to 32 bits so it compares cleanly with the
    // word index of the PC.
    localparam logic [31:0] LP_IMEM_WORDS = 32'(IMEM_WORDS);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_pc_o;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic        r_misalign;
    logic        r_oob;
    logic [31:0] r_fetch_cnt;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [1:0]  w_state_next;
    logic        w_free;
    logic        w_in_range;
    logic        w_target_misaligned;
    logic [31:0] w_pc_plus4;
    logic        w_do_misalign;
    logic        w_do_redirect;
    logic        w_do_oob;
    logic        w_do_capture;
    logic        w_do_consume;

    // The output slot can take a new word when it is empty or being drained.
    assign w_free              = !r_valid || ready_i;
    // Word index of the current PC must lie inside the instruction memory.
    assign w_in_range          = ({2'b00, r_pc[31:2]} < LP_IMEM_WORDS);
    assign w_target_misaligned = (br_target[1:0] != 2'b00);
    // Sequential successor, modulo 2^32.
    assign w_pc_plus4          = r_pc + 32'd4;

    // Pick exactly one action per cycle in RUN, highest priority first.
    always_comb begin
        // NOTE: every signal gets a default before the branches, so no path
        // leaves it unassigned and no latch is inferred.
        w_do_misalign = 1'b0;
        w_do_redirect = 1'b0;
        w_do_oob      = 1'b0;
        w_do_capture  = 1'b0;
        w_do_consume  = 1'b0;
        if (r_state == ST_RUN) begin
            if (br_taken && w_target_misaligned) begin
                w_do_misalign = 1'b1;
            end else if (br_taken) begin
                // Flush wins over stall and over a held, unconsumed output.
                w_do_redirect = 1'b1;
            end else if (w_free && !stall && !w_in_range) begin
                w_do_oob = 1'b1;
            end else if (w_free && !stall) begin
                w_do_capture = 1'b1;
            end else if (r_valid && ready_i) begin
                w_do_consume = 1'b1;
            end
        end
    end

    // Next-state selection for the control FSM.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: w_state_next = ST_RUN;
            ST_RUN: begin
                if (w_do_misalign || w_do_oob) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_FAULT: w_state_next = ST_FAULT;
            default:  w_state_next = ST_FAULT;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Control FSM register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers are written with <= so every flop samples the
        // pre-edge values, independent of block ordering.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Program counter: redirect on a taken branch, step by 4 on capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (w_do_redirect) begin
            r_pc <= br_target;
        end else if (w_do_capture) begin
            r_pc <= w_pc_plus4;
        end
    end

    // Output payload: instruction word, its PC and the sequential successor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst <= 32'd0;
            r_pc_o <= 32'd0;
            r_pc4  <= 32'd0;
        end else if (w_do_capture) begin
            r_inst <= imem_rdata;
            r_pc_o <= r_pc;
            r_pc4  <= w_pc_plus4;
        end
    end

    // Output valid: set by capture, cleared by flush, fault or consumption.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (w_do_misalign || w_do_redirect || w_do_oob || w_do_consume) begin
            r_valid <= 1'b0;
        end else if (w_do_capture) begin
            r_valid <= 1'b1;
        end
    end

    // Sticky fault flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
            r_oob      <= 1'b0;
        end else begin
            if (w_do_misalign) begin
                r_misalign <= 1'b1;
            end
            if (w_do_oob) begin
                r_oob <= 1'b1;
            end
        end
    end

    // Count of captured instructions, wrapping at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= 32'd0;
        end else if (w_do_capture) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_addr  = r_pc;
    assign inst_o     = r_inst;
    assign pc_o       = r_pc_o;
    assign pc4_o      = r_pc4;
    assign valid_o    = r_valid;
    assign misalign_o = r_misalign;
    assign oob_o      = r_oob;
    assign fetch_cnt  = r_fetch_cnt;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed and random checks of fetch_pc_unit.
// Instance A uses the default 2048-word memory and is tracked cycle by cycle
// by a behavioural model. Instance B has a 4-word memory and is checked with
// directed expectations for the out-of-range fault.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;

    // Instance A stimulus and observation
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        ready_i;
    logic [31:0] imem_addr_a;
    logic [31:0] imem_rdata_a;
    logic [31:0] inst_a;
    logic [31:0] pc_a;
    logic [31:0] pc4_a;
    logic        valid_a;
    logic        misalign_a;
    logic        oob_a;
    logic [31:0] cnt_a;

    // Instance B: free-running with constant inputs
    logic        stall_b;
    logic        br_taken_b;
    logic [31:0] br_target_b;
    logic        ready_b;
    logic [31:0] imem_addr_b;
    logic [31:0] imem_rdata_b;
    logic [31:0] inst_b;
    logic [31:0] pc_b;
    logic [31:0] pc4_b;
    logic        valid_b;
    logic        misalign_b;
    logic        oob_b;
    logic [31:0] cnt_b;

    logic [31:0] mem [0:2047];

    int n_checks;
    int n_fail;

    // Behavioural model of instance A
    int          m_mode;   // 0: settling after reset, 1: fetching, 2: dead
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_pc_o;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic        m_mis;
    logic        m_oob;
    logic [31:0] m_cnt;

    fetch_pc_unit #(.RESET_PC(32'h0), .IMEM_WORDS(2048)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .imem_addr  (imem_addr_a),
        .imem_rdata (imem_rdata_a),
        .inst_o     (inst_a),
        .pc_o       (pc_a),
        .pc4_o      (pc4_a),
        .valid_o    (valid_a),
        .ready_i    (ready_i),
        .misalign_o (misalign_a),
        .oob_o      (oob_a),
        .fetch_cnt  (cnt_a)
    );

    fetch_pc_unit #(.RESET_PC(32'h0), .IMEM_WORDS(4)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall_b),
        .br_taken   (br_taken_b),
        .br_target  (br_target_b),
        .imem_addr  (imem_addr_b),
        .imem_rdata (imem_rdata_b),
        .inst_o     (inst_b),
        .pc_o       (pc_b),
        .pc4_o      (pc4_b),
        .valid_o    (valid_b),
        .ready_i    (ready_b),
        .misalign_o (misalign_b),
        .oob_o      (oob_b),
        .fetch_cnt  (cnt_b)
    );

    // Combinational instruction memories
    assign imem_rdata_a = (imem_addr_a[31:13] == 19'd0) ? mem[imem_addr_a[12:2]] : 32'hBAD0_BAD0;
    assign imem_rdata_b = (imem_addr_b[31:4] == 28'd0) ? mem[{9'd0, imem_addr_b[3:2]}] : 32'hBAD0_BAD0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 32'h0;
        m_inst  = 32'h0;
        m_pc_o  = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_oob   = 1'b0;
        m_cnt   = 32'h0;
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_step();
        logic can_take;
        logic fits;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            can_take = !m_valid || ready_i;
            fits     = (m_pc / 4) < 2048;
            if (br_taken && (br_target % 4 != 0)) begin
                m_mis = 1'b1; m_valid = 1'b0; m_mode = 2;
            end else if (br_taken) begin
                m_pc = br_target; m_valid = 1'b0;
            end else if (can_take && !stall && !fits) begin
                m_oob = 1'b1; m_valid = 1'b0; m_mode = 2;
            end else if (can_take && !stall) begin
                m_inst  = mem[m_pc[12:2]];
                m_pc_o  = m_pc;
                m_pc4   = m_pc + 4;
                m_valid = 1'b1;
                m_pc    = m_pc + 4;
                m_cnt   = m_cnt + 1;
            end else if (m_valid && ready_i) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic compare_a(input string tag);
        check({tag, "/imem_addr"}, imem_addr_a, m_pc);
        check({tag, "/inst"},      inst_a,      m_inst);
        check({tag, "/pc_o"},      pc_a,        m_pc_o);
        check({tag, "/pc4_o"},     pc4_a,       m_pc4);
        check({tag, "/valid"},     32'(valid_a),    32'(m_valid));
        check({tag, "/misalign"},  32'(misalign_a), 32'(m_mis));
        check({tag, "/oob"},       32'(oob_a),      32'(m_oob));
        check({tag, "/cnt"},       cnt_a,       m_cnt);
    endtask

    // One clock: update model with current inputs, wait for the edge,
    // then compare a little after it.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_a(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        model_reset();
        compare_a(tag);
        check({tag, "/b_valid"}, 32'(valid_b), 32'd0);
        check({tag, "/b_oob"},   32'(oob_b),   32'd0);
        check({tag, "/b_cnt"},   cnt_b,        32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 32'h0;
        ready_i   = 1'b1;
        stall_b     = 1'b0;
        br_taken_b  = 1'b0;
        br_target_b = 32'h0;
        ready_b     = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            mem[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h0000_0013;
        end
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113;
        mem[3] = 32'h0030_0193;
        model_reset();

        // ---------------- Reset then free-run (A and B together) ---------
        do_reset("reset");
        cycle("idle");
        check("idle/no_valid", 32'(valid_a), 32'd0);
        check("b_idle/no_valid", 32'(valid_b), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycle("run");
            check("run/valid", 32'(valid_a), 32'd1);
            check("run/pc_o", pc_a, 32'(4 * k));
            check("b_run/pc_o", pc_b, 32'(4 * k));
            check("b_run/pc4_o", pc4_b, 32'(4 * k + 4));
            check("b_run/inst", inst_b, mem[k]);
        end
        check("run/inst_c", inst_a, 32'h0030_0193);
        check("run/pc4_c", pc4_a, 32'h10);
        check("run/cnt4", cnt_a, 32'd4);
        cycle("run5");
        check("b_oob/flag", 32'(oob_b), 32'd1);
        check("b_oob/valid", 32'(valid_b), 32'd0);
        check("b_oob/cnt", cnt_b, 32'd4);
        cycle("run6");
        check("b_oob/hold_cnt", cnt_b, 32'd4);
        check("b_oob/hold_pc", pc_b, 32'hC);

        // ---------------- Backpressure ------------------------------------
        do_reset("reset_bp");
        ready_i = 1'b1;
        cycle("bp_idle");
        cycle("bp_c0");
        cycle("bp_c1");
        ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle("bp_hold");
            check("bp_hold/inst", inst_a, 32'h0010_0093);
            check("bp_hold/pc_o", pc_a, 32'h4);
            check("bp_hold/addr", imem_addr_a, 32'h8);
        end
        ready_i = 1'b1;
        cycle("bp_release");
        check("bp_release/pc_o", pc_a, 32'h8);
        check("bp_release/cnt", cnt_a, 32'd3);

        // ---------------- Branch flush with stall -------------------------
        do_reset("reset_br");
        cycle("br_idle");
        cycle("br_c0");
        cycle("br_c1");
        check("br_at8/addr", imem_addr_a, 32'h8);
        stall     = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'h40;
        cycle("br_flush");
        check("br_flush/valid", 32'(valid_a), 32'd0);
        check("br_flush/addr", imem_addr_a, 32'h40);
        check("br_flush/cnt", cnt_a, 32'd2);
        stall    = 1'b0;
        br_taken = 1'b0;
        cycle("br_next");
        check("br_next/pc_o", pc_a, 32'h40);
        check("br_next/inst", inst_a, mem[16]);

        // ---------------- Misaligned redirect ------------------------------
        br_taken  = 1'b1;
        br_target = 32'h42;
        cycle("mis");
        check("mis/flag", 32'(misalign_a), 32'd1);
        check("mis/valid", 32'(valid_a), 32'd0);
        for (int k = 0; k < 6; k++) begin
            br_taken  = 1'($urandom_range(0, 1));
            br_target = {$urandom_range(0, 100), 2'b00};
            ready_i   = 1'($urandom_range(0, 1));
            stall     = 1'($urandom_range(0, 1));
            cycle("mis_frozen");
        end
        check("mis_frozen/addr", imem_addr_a, 32'h44);

        // ---------------- Random segments ----------------------------------
        for (int seg = 0; seg < 6; seg++) begin
            do_reset("reset_rnd");
            stall    = 1'b0;
            br_taken = 1'b0;
            ready_i  = 1'b1;
            for (int k = 0; k < 60; k++) begin
                int r;
                stall   = ($urandom_range(0, 99) < 20);
                ready_i = ($urandom_range(0, 99) < 70);
                r = int'($urandom_range(0, 99));
                br_taken = (r < 12);
                if (r < 1)
                    br_target = {$urandom_range(0, 2047), 2'b10};
                else if (r < 2)
                    br_target = {$urandom_range(2048, 4000), 2'b00};
                else if (r < 4)
                    br_target = 32'h1FF4;
                else
                    br_target = {$urandom_range(0, 2047), 2'b00};
                cycle("rnd");
            end
        end

        // ---------------- Async reset mid-run ------------------------------
        do_reset("reset_async");
        stall    = 1'b0;
        br_taken = 1'b0;
        ready_i  = 1'b1;
        cycle("ar_idle");
        cycle("ar_c0");
        ready_i = 1'b0;
        cycle("ar_c1");
        check("ar_pre/valid", 32'(valid_a), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        compare_a("ar_mid");
        check("ar_mid/addr", imem_addr_a, 32'h0);
        #2;
        rst = 1'b0;
        ready_i = 1'b1;
        cycle("ar_idle2");
        check("ar_idle2/valid", 32'(valid_a), 32'd0);
        cycle("ar_restart");
        check("ar_restart/pc_o", pc_a, 32'h0);
        check("ar_restart/inst", inst_a, 32'h0000_0013);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
